// File: rtl/nanci_row_drain.sv
// nanci_row_drain: snapshots one mesh row of PE outputs and streams the
// elements out over valid/ready, reversing odd rows when snake ordering is on.
module nanci_row_drain #(
    parameter int unsigned N          = 4,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 3,
    parameter int          ROW_IDX    = 0,
    parameter int unsigned SNAKE      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_capture,
    input  logic [N*(ADDR_WIDTH+DATA_WIDTH)-1:0]  i_row,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0]      o_data,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic                                  o_last,
    output logic                                  o_busy,
    output logic                                  o_overrun
);

    localparam int unsigned W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam bit          REV = (SNAKE != 0) && ((ROW_IDX % 2) != 0);
    localparam logic [IW-1:0] FIRST_IDX = REV ? IW'(N - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX  = REV ? '0 : IW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    buf_q [N];
    logic [W-1:0]    buf_d [N];
    logic [W-1:0]    data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic            load;

    // Next-state, snapshot load and registered output values.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        data_d    = '0;

        case (state_q)
            IDLE: begin
                if (i_capture) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (i_ready) begin
                    if (idx_q == LAST_IDX) begin
                        // A capture on the final transfer chains straight into the next row.
                        if (i_capture) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = REV ? (idx_q - IW'(1)) : (idx_q + IW'(1));
                    end
                end
                if (i_capture && !(i_ready && (idx_q == LAST_IDX))) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            idx_d = FIRST_IDX;
            for (int k = 0; k < int'(N); k++) begin
                buf_d[k] = i_row[k*W +: W];
            end
        end

        if (state_d == SEND) begin
            for (int k = 0; k < int'(N); k++) begin
                if (idx_d == IW'(k)) begin
                    data_d = buf_d[k];
                end
            end
        end

        valid_d = (state_d == SEND);
        busy_d  = (state_d == SEND);
        last_d  = (state_d == SEND) && (idx_d == LAST_IDX);
    end

    // State, snapshot buffer and output registers; reset discards any snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < int'(N); k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            buf_q     <= buf_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_last    = last_q;
    assign o_busy    = busy_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_nanci_row_drain.sv
// Scoreboard bench for nanci_row_drain: ascending, snake, non-snake and N=1 rows.
module tb_nanci_row_drain;

    localparam int W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Row A elements k0..k3 and the two filler rows
    localparam logic [W-1:0] A0 = 6'b000101;
    localparam logic [W-1:0] A1 = 6'b001011;
    localparam logic [W-1:0] A2 = 6'b010010;
    localparam logic [W-1:0] A3 = 6'b011111;
    localparam logic [W-1:0] BV = 6'b111000;
    localparam logic [W-1:0] CV = 6'b100001;
    localparam logic [4*W-1:0] ROW_A = {A3, A2, A1, A0};
    localparam logic [4*W-1:0] ROW_B = {BV, BV, BV, BV};
    localparam logic [4*W-1:0] ROW_C = {CV, CV, CV, CV};

    // dut0: N=4 ROW_IDX=0 ; dut1: ROW_IDX=1 snake ; dut2: ROW_IDX=1 no snake ; dut3: N=1
    logic           rst0, cap0, rdy0;
    logic [4*W-1:0] row0;
    logic [W-1:0]   data0;
    logic           valid0, last0, busy0, ovr0;

    logic           rstg, cap1, cap2, cap3;
    logic [4*W-1:0] row1, row2;
    logic [W-1:0]   row3;
    logic [W-1:0]   data1, data2, data3;
    logic           valid1, last1, busy1, ovr1;
    logic           valid2, last2, busy2, ovr2;
    logic           valid3, last3, busy3, ovr3;

    nanci_row_drain #(.N(4), .ADDR_WIDTH(3), .DATA_WIDTH(3), .ROW_IDX(0), .SNAKE(1)) dut0 (
        .clk(clk), .rst(rst0), .i_capture(cap0), .i_row(row0), .o_data(data0),
        .o_valid(valid0), .i_ready(rdy0), .o_last(last0), .o_busy(busy0), .o_overrun(ovr0));
    nanci_row_drain #(.N(4), .ADDR_WIDTH(3), .DATA_WIDTH(3), .ROW_IDX(1), .SNAKE(1)) dut1 (
        .clk(clk), .rst(rstg), .i_capture(cap1), .i_row(row1), .o_data(data1),
        .o_valid(valid1), .i_ready(1'b1), .o_last(last1), .o_busy(busy1), .o_overrun(ovr1));
    nanci_row_drain #(.N(4), .ADDR_WIDTH(3), .DATA_WIDTH(3), .ROW_IDX(1), .SNAKE(0)) dut2 (
        .clk(clk), .rst(rstg), .i_capture(cap2), .i_row(row2), .o_data(data2),
        .o_valid(valid2), .i_ready(1'b1), .o_last(last2), .o_busy(busy2), .o_overrun(ovr2));
    nanci_row_drain #(.N(1), .ADDR_WIDTH(3), .DATA_WIDTH(3), .ROW_IDX(0), .SNAKE(1)) dut3 (
        .clk(clk), .rst(rstg), .i_capture(cap3), .i_row(row3), .o_data(data3),
        .o_valid(valid3), .i_ready(1'b1), .o_last(last3), .o_busy(busy3), .o_overrun(ovr3));

    // Expected {last, data} per instance
    logic [W:0] q0[$];
    logic [W:0] q1[$];
    logic [W:0] q2[$];
    logic [W:0] q3[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_xfer(input string name, input logic [W:0] got, inout logic [W:0] q[$]);
        logic [W:0] e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected: got %0h expected none at %0t", name, got, $time);
        end else begin
            e = q.pop_front();
            chk({name, " data"}, 32'(got[W-1:0]), 32'(e[W-1:0]));
            chk({name, " last"}, 32'(got[W]), 32'(e[W]));
        end
    endtask

    // Monitors: a transfer is valid && ready at a non-reset edge
    always @(negedge clk) begin
        if (valid0 && rdy0 && !rst0) cmp_xfer("d0", {last0, data0}, q0);
        if (valid1 && !rstg) cmp_xfer("d1_snake", {last1, data1}, q1);
        if (valid2 && !rstg) cmp_xfer("d2_nosnake", {last2, data2}, q2);
        if (valid3 && !rstg) cmp_xfer("d3_n1", {last3, data3}, q3);
    end

    task automatic push_a0();
        q0.push_back({1'b0, A0}); q0.push_back({1'b0, A1});
        q0.push_back({1'b0, A2}); q0.push_back({1'b1, A3});
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_idle0(input string name);
        @(negedge clk);
        chk({name, " valid"}, 32'(valid0), 0);
        chk({name, " last"},  32'(last0), 0);
        chk({name, " busy"},  32'(busy0), 0);
        chk({name, " data"},  32'(data0), 0);
    endtask

    initial begin
        rst0 = 1'b1; cap0 = 1'b0; rdy0 = 1'b1; row0 = ROW_A;
        rstg = 1'b1; cap1 = 1'b0; cap2 = 1'b0; cap3 = 1'b0;
        row1 = ROW_A; row2 = ROW_A; row3 = A0;
        tick(); tick();
        rst0 = 1'b0; rstg = 1'b0;
        chk_idle0("reset");
        chk("reset overrun", 32'(ovr0), 0);
        tick();

        // Snake, non-snake and N=1 rows, captured together
        q1.push_back({1'b0, A3}); q1.push_back({1'b0, A2});
        q1.push_back({1'b0, A1}); q1.push_back({1'b1, A0});
        q2.push_back({1'b0, A0}); q2.push_back({1'b0, A1});
        q2.push_back({1'b0, A2}); q2.push_back({1'b1, A3});
        q3.push_back({1'b1, A0});
        cap1 = 1'b1; cap2 = 1'b1; cap3 = 1'b1;
        tick();
        cap1 = 1'b0; cap2 = 1'b0; cap3 = 1'b0;
        @(negedge clk);
        chk("n1 busy offered", 32'(busy3), 1);
        tick();
        @(negedge clk);
        chk("n1 idle after one", 32'(valid3), 0);
        repeat (4) tick();
        chk("snake idle", 32'(busy1), 0);

        // Plain ascending drain
        push_a0();
        cap0 = 1'b1; tick(); cap0 = 1'b0;
        repeat (4) tick();
        chk_idle0("after drain");

        // Reset after two transfers, then restart from element 0
        push_a0();
        cap0 = 1'b1; tick(); cap0 = 1'b0;
        tick(); tick();
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        chk_idle0("mid-drain reset");
        chk("mid-drain reset overrun", 32'(ovr0), 0);
        chk("discarded count", 32'(q0.size()), 2);
        q0.delete();
        push_a0();
        cap0 = 1'b1; tick(); cap0 = 1'b0;
        repeat (4) tick();

        // Backpressure: hold first element for three cycles
        push_a0();
        rdy0 = 1'b0;
        cap0 = 1'b1; tick(); cap0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall valid", 32'(valid0), 1);
            chk("stall data", 32'(data0), 32'(A0));
            tick();
        end
        rdy0 = 1'b1;
        repeat (5) tick();

        // Back-to-back capture on the last transfer
        push_a0();
        for (int i = 0; i < 3; i++) q0.push_back({1'b0, CV});
        q0.push_back({1'b1, CV});
        cap0 = 1'b1; tick(); cap0 = 1'b0;
        tick(); tick(); tick();
        cap0 = 1'b1; row0 = ROW_C; tick(); cap0 = 1'b0; row0 = ROW_A;
        @(negedge clk);
        chk("b2b valid", 32'(valid0), 1);
        chk("b2b overrun", 32'(ovr0), 0);
        repeat (4) tick();
        chk_idle0("after b2b");

        // Overrun: capture while second element is offered
        push_a0();
        cap0 = 1'b1; tick(); cap0 = 1'b0;
        tick();
        cap0 = 1'b1; row0 = ROW_B; tick(); cap0 = 1'b0; row0 = ROW_A;
        @(negedge clk);
        chk("overrun set", 32'(ovr0), 1);
        repeat (3) tick();
        @(negedge clk);
        chk("overrun sticky", 32'(ovr0), 1);
        chk("overrun drained", 32'(busy0), 0);
        tick();

        chk("q0 empty", 32'(q0.size()), 0);
        chk("q1 empty", 32'(q1.size()), 0);
        chk("q2 empty", 32'(q2.size()), 0);
        chk("q3 empty", 32'(q3.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
